// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: ISA opcodes, field positions, flags register and instruction decode helper
package decode_issue_pkg;
  localparam logic [2:0] FLAGS_REG = 3'd7;
  localparam int F_OPC = 12;
  localparam int F_RD = 9;
  localparam int F_RS1 = 6;
  localparam int F_I = 5;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_LD, OP_ST, OP_SUB, OP_MUL, OP_CMP,
    OP_MOV, OP_OR, OP_AND, OP_NOT, OP_LSL, OP_LSR
  } opcode_t;
  typedef struct packed {
    logic       valid;
    logic       has_dst;
    logic [2:0] dst;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
  } dec_t;
  function automatic dec_t decode(input logic [15:0] i);
    dec_t d;
    logic [3:0] op;
    op = i[F_OPC+:4];
    d.valid = op >= OP_ADD && op <= OP_LSR;
    d.has_dst = d.valid && op != OP_ST;
    d.dst = op == OP_CMP ? FLAGS_REG : i[F_RD+:3];
    d.use_rs1 = d.valid && op != OP_MOV;
    d.use_rs2 = d.valid && !i[F_I] && op != OP_NOT;
    d.use_rd = op == OP_ST;
    return d;
  endfunction
endpackage

// File: rtl/decode_issue_regfile_scoreboard.sv
// decode_issue_regfile_scoreboard: register file with write-first read ports and busy-bit scoreboard
module decode_issue_regfile_scoreboard #(
  parameter int NREGS = 8,
  parameter int XLEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ra1,
  input  logic [2:0]       ra2,
  input  logic [2:0]       ra3,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  output logic [XLEN-1:0]  rd3,
  output logic [NREGS-1:0] busy,
  input  logic             set_en,
  input  logic [2:0]       set_rd,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [2:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q, clr, set;
  logic wr;
  // Same-cycle writeback is visible to reads and to the busy view used for hazards
  always_comb begin
    wr = wb_valid && wb_we;
    clr = wb_valid ? NREGS'(1) << wb_rd : '0;
    set = set_en ? NREGS'(1) << set_rd : '0;
    busy = busy_q & ~clr;
    rd1 = wr && wb_rd == ra1 ? wb_data : regs[ra1];
    rd2 = wr && wb_rd == ra2 ? wb_data : regs[ra2];
    rd3 = wr && wb_rd == ra3 ? wb_data : regs[ra3];
  end
  // Clear on retirement, then set on issue so a new issue wins over a same-register retirement
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      busy_q <= busy | set;
      if (wr) regs[wb_rd] <= wb_data;
    end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode, RAW/WAW interlock and issue register feeding the execute ALU
module decode_issue import decode_issue_pkg::*; #(
  parameter int NREGS = 8,
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instrin,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_branch_takenin,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [2:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [11:0]     alusignals,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [4:0]      immx,
  output logic            isimmediate,
  output logic [XLEN-1:0] stdata,
  output logic [15:0]     instrout,
  output logic            out_valid,
  output logic [15:0]     stall_cycles
);
  dec_t dec;
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0] r1, r2, r3;
  logic hazard, issue;
  assign dec = decode(instrin);
  decode_issue_regfile_scoreboard #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk(clk), .reset(reset),
    .ra1(instrin[F_RS1+:3]), .ra2(instrin[2:0]), .ra3(instrin[F_RD+:3]),
    .rd1(r1), .rd2(r2), .rd3(r3), .busy(busy),
    .set_en(issue && dec.has_dst), .set_rd(dec.dst),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  // Interlock on any busy source or busy destination of the held instruction
  always_comb begin
    hazard = (dec.use_rs1 && busy[instrin[F_RS1+:3]]) || (dec.use_rs2 && busy[instrin[2:0]]) ||
             (dec.use_rd && busy[instrin[F_RD+:3]]) || (dec.has_dst && busy[dec.dst]);
    issue = in_valid && !hazard && !is_branch_takenin && dec.valid;
    in_ready = !hazard && !reset;
  end
  // Output register: issued instruction or an all-zero bubble every cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alusignals <= '0;
      op1 <= '0;
      op2 <= '0;
      immx <= '0;
      isimmediate <= 1'b0;
      stdata <= '0;
      instrout <= '0;
      out_valid <= 1'b0;
    end else begin
      alusignals <= issue ? 12'(1) << (instrin[F_OPC+:4] - 4'd1) : '0;
      op1 <= issue ? r1 : '0;
      op2 <= issue ? r2 : '0;
      immx <= issue ? instrin[4:0] : '0;
      isimmediate <= issue && instrin[F_I];
      stdata <= issue && dec.use_rd ? r3 : '0;
      instrout <= issue ? instrin : '0;
      out_valid <= issue;
    end
  // Saturating count of cycles a valid instruction is held by the interlock
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cycles <= '0;
    else if (in_valid && hazard && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: vector table, directed corner sequences and randomized run against a reference model
module tb_decode_issue;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] instrin = '0;
  logic in_valid = 1'b0, in_ready, is_branch_takenin = 1'b0;
  logic wb_valid = 1'b0, wb_we = 1'b0;
  logic [2:0] wb_rd = '0;
  logic [15:0] wb_data = '0;
  logic [11:0] alusignals;
  logic [15:0] op1, op2, stdata, instrout, stall_cycles;
  logic [4:0] immx;
  logic isimmediate, out_valid;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset), .instrin(instrin), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch_takenin(is_branch_takenin), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .alusignals(alusignals), .op1(op1), .op2(op2), .immx(immx),
    .isimmediate(isimmediate), .stdata(stdata), .instrout(instrout), .out_valid(out_valid),
    .stall_cycles(stall_cycles)
  );

  int pass_n = 0, total_n = 0;
  logic [15:0] m_r [8];
  logic [7:0] m_busy;
  logic [15:0] m_stall;
  logic [11:0] e_alu;
  logic [15:0] e_op1, e_op2, e_std, e_ins;
  logic [4:0] e_imm;
  logic e_isi, e_ov;

  typedef struct {
    logic [15:0] ins;
    logic [11:0] alu;
    logic [15:0] op1, op2, std;
    logic [4:0] imm;
    logic isi, ov;
    int ret;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] srcmask(input logic [15:0] ins);
    int rdn = int'(ins[11:9]), rs1 = int'(ins[8:6]), rs2 = int'(ins[2:0]);
    logic [7:0] a, b, c;
    a = 8'(1) << rs1;
    b = ins[5] ? 8'h00 : 8'(1) << rs2;
    c = 8'(1) << rdn;
    case (ins[15:12])
      4'd7: return b;
      4'd10: return a;
      4'd3: return a | b | c;
      4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11, 4'd12: return a | b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int dstreg(input logic [15:0] ins);
    case (ins[15:12])
      4'd3: return -1;
      4'd6: return 7;
      4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: return int'(ins[11:9]);
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_busy = '0;
    m_stall = '0;
    {e_alu, e_op1, e_op2, e_std, e_ins, e_imm, e_isi, e_ov} = '0;
  endtask

  task automatic check_out();
    chk("alusignals", alusignals, e_alu);
    chk("op1", op1, e_op1);
    chk("op2", op2, e_op2);
    chk("immx", immx, e_imm);
    chk("isimmediate", isimmediate, e_isi);
    chk("stdata", stdata, e_std);
    chk("instrout", instrout, e_ins);
    chk("out_valid", out_valid, e_ov);
    chk("stall_cycles", stall_cycles, m_stall);
  endtask

  // one clock: drive at negedge, check in_ready, clock, check registered outputs against the model
  task automatic cycle(input logic iv, input logic [15:0] ins, input logic fl,
                       input logic wv, input logic we, input logic [2:0] wrd, input logic [15:0] wd);
    logic [7:0] bz, dm;
    logic [15:0] rn [8];
    logic haz, issue;
    int d;
    in_valid = iv; instrin = ins; is_branch_takenin = fl;
    wb_valid = wv; wb_we = we; wb_rd = wrd; wb_data = wd;
    bz = m_busy;
    rn = m_r;
    if (wv) bz[wrd] = 1'b0;
    if (wv && we) rn[wrd] = wd;
    d = dstreg(ins);
    dm = d < 0 ? 8'h00 : 8'(1) << d;
    haz = |(bz & (srcmask(ins) | dm));
    #1;
    chk("in_ready", in_ready, !haz);
    @(posedge clk);
    #1;
    issue = iv && !haz && !fl && ins[15:12] >= 4'd1 && ins[15:12] <= 4'd12;
    m_r = rn;
    m_busy = bz;
    if (issue && d >= 0) m_busy[d] = 1'b1;
    if (iv && haz && m_stall != 16'hFFFF) m_stall++;
    e_ov = issue;
    e_alu = issue ? 12'(1) << (ins[15:12] - 4'd1) : '0;
    e_op1 = issue ? rn[ins[8:6]] : '0;
    e_op2 = issue ? rn[ins[2:0]] : '0;
    e_std = issue && ins[15:12] == 4'd3 ? rn[ins[11:9]] : '0;
    e_imm = issue ? ins[4:0] : '0;
    e_isi = issue && ins[5];
    e_ins = issue ? ins : '0;
    check_out();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic retire(input int r);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'(r), 16'hDEAD);
  endtask

  initial begin
    logic [15:0] s0;
    tbl[0] = '{16'h1283, 12'h001, 16'h2222, 16'h3333, 16'h0000, 5'd3, 1'b0, 1'b1, 1};
    tbl[1] = '{16'h2966, 12'h002, 16'h5555, 16'h6666, 16'h0000, 5'd6, 1'b1, 1'b1, 4};
    tbl[2] = '{16'h3C62, 12'h004, 16'h1111, 16'h2222, 16'h6666, 5'd2, 1'b1, 1'b1, -1};
    tbl[3] = '{16'hC1C1, 12'h800, 16'h7777, 16'h1111, 16'h0000, 5'd1, 1'b0, 1'b1, 0};
    tbl[4] = '{16'hE123, 12'h000, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0, -1};
    tbl[5] = '{16'hA700, 12'h200, 16'h4444, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1, 3};
    tbl[6] = '{16'h5482, 12'h010, 16'h2222, 16'h2222, 16'h0000, 5'd2, 1'b0, 1'b1, 2};
    tbl[7] = '{16'h6046, 12'h020, 16'h1111, 16'h6666, 16'h0000, 5'd6, 1'b0, 1'b1, 7};
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_out();
    chk("in_ready_in_reset", in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("in_ready_after_reset", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'(i), 16'(16'h1111 * i));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].ins, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
      chk("tbl_alu", alusignals, tbl[i].alu);
      chk("tbl_op1", op1, tbl[i].op1);
      chk("tbl_op2", op2, tbl[i].op2);
      chk("tbl_stdata", stdata, tbl[i].std);
      chk("tbl_immx", immx, tbl[i].imm);
      chk("tbl_isimm", isimmediate, tbl[i].isi);
      chk("tbl_valid", out_valid, tbl[i].ov);
      if (tbl[i].ret >= 0) retire(tbl[i].ret);
      else idle();
    end
    cycle(1'b1, 16'h12A9, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    s0 = stall_cycles;
    repeat (3) cycle(1'b1, 16'h4842, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("raw_stall_count", stall_cycles, 16'(s0 + 16'd3));
    chk("raw_stall_bubble", out_valid, 1'b0);
    cycle(1'b1, 16'h4842, 1'b0, 1'b1, 1'b1, 3'd1, 16'h000C);
    chk("raw_sub_op1", op1, 16'h000C);
    chk("raw_sub_alu", alusignals, 12'h008);
    retire(4);
    cycle(1'b1, 16'h6083, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    repeat (2) cycle(1'b1, 16'h7A07, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("flags_stall", in_ready, 1'b0);
    cycle(1'b1, 16'h7A07, 1'b0, 1'b1, 1'b1, 3'd7, 16'h0003);
    chk("flags_mov_op2", op2, 16'h0003);
    chk("flags_mov_alu", alusignals, 12'h040);
    retire(5);
    cycle(1'b1, 16'h1283, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    cycle(1'b1, 16'h1483, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_instrout", instrout, 16'h0000);
    retire(1);
    cycle(1'b1, 16'h1641, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("killed_keeps_r1", op1, 16'h000C);
    chk("killed_busy_clear", out_valid, 1'b1);
    retire(3);
    cycle(1'b1, 16'h1682, 1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF);
    chk("bypass_op1", op1, 16'hBEEF);
    chk("bypass_op2", op2, 16'hBEEF);
    retire(3);
    cycle(1'b1, 16'hE123, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("bad_opcode_bubble", out_valid, 1'b0);
    cycle(1'b1, 16'h1200, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("bad_opcode_no_busy", out_valid, 1'b1);
    retire(1);
    cycle(1'b1, 16'h12A9, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    cycle(1'b1, 16'h4842, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    in_valid = 1'b1; instrin = 16'h4842;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_stall_cycles", stall_cycles, 16'h0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_instrout", instrout, 16'h0000);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_busy_cleared", in_ready, 1'b1);
    cycle(1'b1, 16'h4842, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("rst_regs_cleared", op1, 16'h0000);
    retire(4);
    for (int n = 0; n < 400; n++) begin
      logic wv, we;
      logic [2:0] wrd;
      int st;
      wv = 1'b0;
      wrd = '0;
      we = 1'(($urandom & 1));
      if (m_busy != 8'h00 && $urandom_range(0, 1) == 1) begin
        st = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++)
          if (!wv && m_busy[(st + k) % 8]) begin
            wv = 1'b1;
            wrd = 3'((st + k) % 8);
          end
      end
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0, wv, we, wrd, 16'($urandom));
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
